// File: rtl/vesp_top.sv
// Single-cycle RV32I system: one core plus a unified instruction/data RAM.
// All state updates on the rising edge of sysClk; sysRes is synchronous, active-high.

module vesp_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic        we_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] rf [0:31];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we_i && (rd_i != 5'd0)) begin
            rf[rd_i] <= wd_i;
        end
    end

    assign rd1_o = (rs1_i == 5'd0) ? '0 : rf[rs1_i];
    assign rd2_o = (rs2_i == 5'd0) ? '0 : rf[rs2_i];
endmodule

module vesp_cpu (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] iaddr_o,
    input  logic [31:0] idata_i,
    output logic [31:0] daddr_o,
    input  logic [31:0] drdata_i,
    output logic [31:0] dwdata_o,
    output logic [3:0]  dbe_o,
    output logic        dwe_o
);
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;

    logic [31:0] PC;
    logic [31:0] instruction;
    logic [31:0] pc_d, pc4;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_res, wb_val, mem_addr;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        wb_en, st_en, br_taken;
    logic [3:0]  st_be;
    logic [31:0] st_data;

    assign instruction = idata_i;
    assign iaddr_o     = PC;
    assign opcode      = instruction[6:0];
    assign funct3      = instruction[14:12];
    assign pc4         = PC + 32'd4;

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'h000};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    vesp_regfile regfile (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rs1_i (instruction[19:15]),
        .rs2_i (instruction[24:20]),
        .rd_i  (instruction[11:7]),
        .we_i  (wb_en & ~rst_i),
        .wd_i  (wb_val),
        .rd1_o (rs1_val),
        .rd2_o (rs2_val)
    );

    // Bit 30 selects SUB only for register-register ops; for shifts it selects SRA in both forms.
    assign alu_b = (opcode == OP_OP) ? rs2_val : imm_i;
    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = ((opcode == OP_OP) && instruction[30]) ? rs1_val - alu_b
                                                                    : rs1_val + alu_b;
            3'b001: alu_res = rs1_val << alu_b[4:0];
            3'b010: alu_res = ($signed(rs1_val) < $signed(alu_b)) ? 32'd1 : 32'd0;
            3'b011: alu_res = (rs1_val < alu_b) ? 32'd1 : 32'd0;
            3'b100: alu_res = rs1_val ^ alu_b;
            3'b101: begin
                if (instruction[30]) alu_res = $signed(rs1_val) >>> alu_b[4:0];
                else                 alu_res = rs1_val >> alu_b[4:0];
            end
            3'b110: alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign ld_half  = mem_addr[1] ? drdata_i[31:16] : drdata_i[15:0];
    always_comb begin
        case (mem_addr[1:0])
            2'd0:    ld_byte = drdata_i[7:0];
            2'd1:    ld_byte = drdata_i[15:8];
            2'd2:    ld_byte = drdata_i[23:16];
            default: ld_byte = drdata_i[31:24];
        endcase
    end

    always_comb begin
        pc_d    = pc4;
        wb_en   = 1'b0;
        wb_val  = alu_res;
        st_en   = 1'b0;
        st_be   = 4'b0000;
        st_data = rs2_val;
        case (opcode)
            OP_LUI:   begin wb_en = 1'b1; wb_val = imm_u; end
            OP_AUIPC: begin wb_en = 1'b1; wb_val = PC + imm_u; end
            OP_JAL:   begin wb_en = 1'b1; wb_val = pc4; pc_d = PC + imm_j; end
            OP_JALR:  begin wb_en = 1'b1; wb_val = pc4; pc_d = (rs1_val + imm_i) & ~32'd1; end
            OP_BRANCH: if (br_taken) pc_d = PC + imm_b;
            OP_LOAD: begin
                case (funct3)
                    3'b000: begin wb_en = 1'b1; wb_val = {{24{ld_byte[7]}}, ld_byte}; end
                    3'b001: begin wb_en = 1'b1; wb_val = {{16{ld_half[15]}}, ld_half}; end
                    3'b010: begin wb_en = 1'b1; wb_val = drdata_i; end
                    3'b100: begin wb_en = 1'b1; wb_val = {24'h0, ld_byte}; end
                    3'b101: begin wb_en = 1'b1; wb_val = {16'h0, ld_half}; end
                    default: ;
                endcase
            end
            OP_STORE: begin
                case (funct3)
                    3'b000: begin
                        st_en = 1'b1; st_data = {4{rs2_val[7:0]}};
                        st_be = 4'b0001 << mem_addr[1:0];
                    end
                    3'b001: begin
                        st_en = 1'b1; st_data = {2{rs2_val[15:0]}};
                        st_be = mem_addr[1] ? 4'b1100 : 4'b0011;
                    end
                    3'b010: begin st_en = 1'b1; st_be = 4'b1111; end
                    default: ;
                endcase
            end
            OP_IMM, OP_OP: wb_en = 1'b1;
            default: ;
        endcase
    end

    assign daddr_o  = mem_addr;
    assign dwdata_o = st_data;
    assign dbe_o    = st_be;
    assign dwe_o    = st_en & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) PC <= '0;
        else       PC <= {pc_d[31:2], 2'b00};
    end
endmodule

module vesp_ram #(
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk_i,
    input  logic [31:0] iaddr_i,
    output logic [31:0] idata_o,
    input  logic [31:0] daddr_i,
    output logic [31:0] drdata_o,
    input  logic [31:0] dwdata_i,
    input  logic [3:0]  dbe_i,
    input  logic        dwe_i
);
    localparam int AW = $clog2(MEM_WORDS);

    reg   [31:0]   RAM [0:MEM_WORDS-1];
    logic [AW-1:0] iidx, didx;
    logic          unused_addr_bits;

    // Upper address bits are dropped so accesses wrap around the RAM.
    assign iidx = iaddr_i[AW+1:2];
    assign didx = daddr_i[AW+1:2];
    assign unused_addr_bits = ^{iaddr_i[31:AW+2], iaddr_i[1:0], daddr_i[31:AW+2], daddr_i[1:0]};

    assign idata_o  = RAM[iidx];
    assign drdata_o = RAM[didx];

    always_ff @(posedge clk_i) begin
        if (dwe_i) begin
            for (int b = 0; b < 4; b++) begin
                if (dbe_i[b]) RAM[didx][8*b +: 8] <= dwdata_i[8*b +: 8];
            end
        end
    end
endmodule

module vesp_top #(
    parameter int MEM_WORDS = 4096
) (
    input logic sysClk,
    input logic sysRes
);
    logic [31:0] instrBusData, instrAddr, dataAddr, dataRdData, dataWrData;
    logic [3:0]  dataBe;
    logic        dataWe;

    vesp_cpu cpu (
        .clk_i    (sysClk),
        .rst_i    (sysRes),
        .iaddr_o  (instrAddr),
        .idata_i  (instrBusData),
        .daddr_o  (dataAddr),
        .drdata_i (dataRdData),
        .dwdata_o (dataWrData),
        .dbe_o    (dataBe),
        .dwe_o    (dataWe)
    );

    vesp_ram #(.MEM_WORDS(MEM_WORDS)) ramMain (
        .clk_i    (sysClk),
        .iaddr_i  (instrAddr),
        .idata_o  (instrBusData),
        .daddr_i  (dataAddr),
        .drdata_o (dataRdData),
        .dwdata_i (dataWrData),
        .dbe_i    (dataBe),
        .dwe_i    (dataWe)
    );
endmodule

// File: tb/tb_vesp_top.sv
// Bench for vesp_top: directed program tables, control-flow/reset sequences,
// and random ALU/load/store programs checked against an instruction-level model.

module tb_vesp_top;
    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
    localparam logic [6:0] BR = 7'h63, LD = 7'h03, ST = 7'h23, OPI = 7'h13;

    logic sysClk = 1'b0;
    logic sysRes = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_mem [0:4095];
    logic [31:0] m_x   [0:31];
    logic [31:0] m_pc;

    typedef struct packed {
        logic [31:0] ins;
        logic        is_mem;
        logic [11:0] idx;
        logic [31:0] exp;
    } vec_t;

    vesp_top dut (.sysClk(sysClk), .sysRes(sysRes));

    always #5 sysClk = ~sysClk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] e_i(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] e_s(input logic [2:0] f3, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], ST};
    endfunction

    function automatic logic [31:0] e_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BR};
    endfunction

    function automatic logic [31:0] e_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
    endfunction

    function automatic logic [31:0] e_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    function automatic vec_t mk(input logic [31:0] ins, input logic is_mem,
                                input logic [11:0] idx, input logic [31:0] exp);
        vec_t v;
        v.ins = ins; v.is_mem = is_mem; v.idx = idx; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        dut.ramMain.RAM[idx] = v;
        m_mem[idx] = v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) poke(i, 32'h0);
    endtask

    task automatic do_reset();
        sysRes = 1'b1;
        @(negedge sysClk);
        sysRes = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge sysClk);
    endtask

    // Instruction-level reference: one architectural step from the model state.
    task automatic model_step();
        logic [31:0] ins, a, b, r, addr, w;
        logic [7:0]  bt;
        logic [15:0] hw;
        logic        wr;
        ins = m_mem[m_pc[13:2]];
        a = m_x[ins[19:15]];
        b = m_x[ins[24:20]];
        r = 32'h0;
        wr = 1'b1;
        case (ins[6:0])
            LUI:   r = {ins[31:12], 12'h000};
            AUIPC: r = m_pc + {ins[31:12], 12'h000};
            OPI, 7'h33: begin
                if (ins[6:0] == OPI) b = {{20{ins[31]}}, ins[31:20]};
                case (ins[14:12])
                    3'd0: r = (ins[5] && ins[30]) ? a - b : a + b;
                    3'd1: r = a << b[4:0];
                    3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: r = (a < b) ? 32'd1 : 32'd0;
                    3'd4: r = a ^ b;
                    3'd5: begin
                        if (ins[30]) r = $signed(a) >>> b[4:0];
                        else         r = a >> b[4:0];
                    end
                    3'd6: r = a | b;
                    default: r = a & b;
                endcase
            end
            LD: begin
                addr = a + {{20{ins[31]}}, ins[31:20]};
                w  = m_mem[addr[13:2]];
                bt = w[8*addr[1:0] +: 8];
                hw = w[16*addr[1] +: 16];
                case (ins[14:12])
                    3'd0: r = {{24{bt[7]}}, bt};
                    3'd1: r = {{16{hw[15]}}, hw};
                    3'd2: r = w;
                    3'd4: r = {24'h0, bt};
                    3'd5: r = {16'h0, hw};
                    default: wr = 1'b0;
                endcase
            end
            ST: begin
                wr = 1'b0;
                addr = a + {{20{ins[31]}}, ins[31:25], ins[11:7]};
                case (ins[14:12])
                    3'd0: m_mem[addr[13:2]][8*addr[1:0] +: 8] = b[7:0];
                    3'd1: m_mem[addr[13:2]][16*addr[1] +: 16] = b[15:0];
                    3'd2: m_mem[addr[13:2]] = b;
                    default: ;
                endcase
            end
            default: wr = 1'b0;
        endcase
        if (wr && ins[11:7] != 5'd0) m_x[ins[11:7]] = r;
        m_pc = m_pc + 32'd4;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int k;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        imm = 12'($urandom);
        f3  = 3'($urandom_range(0, 7));
        k   = int'($urandom_range(0, 9));
        case (k)
            0, 1, 2: begin
                if (f3 == 3'd1)      imm = {7'd0, imm[4:0]};
                else if (f3 == 3'd5) imm = {1'b0, imm[10], 5'd0, imm[4:0]};
                return e_i(OPI, f3, rd, rs1, imm);
            end
            3, 4, 5: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return e_r(f7, rs2, rs1, f3, rd);
            end
            6: return e_u(($urandom_range(0, 1) == 1) ? LUI : AUIPC, rd, 20'($urandom));
            7, 8: begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
                return e_i(LD, f3, rd, 5'd0, 12'h600 + 12'($urandom_range(0, 511)));
            end
            default: begin
                case ($urandom_range(0, 2))
                    0: return e_s(3'd0, rs2, 5'd0, 12'h600 + 12'($urandom_range(0, 511)));
                    1: return e_s(3'd1, rs2, 5'd0, 12'h600 + 12'(2 * $urandom_range(0, 255)));
                    default: return e_s(3'd2, rs2, 5'd0, 12'h600 + 12'(4 * $urandom_range(0, 127)));
                endcase
            end
        endcase
    endfunction

    vec_t tbl [0:23];
    logic [31:0] old_word, sw_ins;

    initial begin
        // Reset and first fetch
        clear_mem();
        poke(0, 32'h00500093);
        poke(1, 32'h00000073);
        do_reset();
        chk("reset_pc", dut.cpu.PC, 32'h0);
        chk("reset_fetch", dut.instrBusData, 32'h00500093);
        step(1);
        chk("first_pc", dut.cpu.PC, 32'h4);
        chk("first_x1", dut.cpu.regfile.rf[1], 32'h5);
        chk("first_next_fetch", dut.instrBusData, 32'h00000073);
        chk("copy_instruction", dut.cpu.instruction, 32'h00000073);

        // Straight-line table: each entry names the register or RAM word it must leave behind
        tbl[0]  = mk(e_i(OPI, 3'd0, 5'd1, 5'd0, 12'hFF8), 1'b0, 12'd1, 32'hFFFFFFF8);
        tbl[1]  = mk(e_i(OPI, 3'd5, 5'd2, 5'd1, 12'h401), 1'b0, 12'd2, 32'hFFFFFFFC);
        tbl[2]  = mk(e_i(OPI, 3'd5, 5'd3, 5'd1, 12'h001), 1'b0, 12'd3, 32'h7FFFFFFC);
        tbl[3]  = mk(e_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd4),  1'b0, 12'd4, 32'h1);
        tbl[4]  = mk(e_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd5),  1'b0, 12'd5, 32'h8);
        tbl[5]  = mk(e_i(OPI, 3'd0, 5'd0, 5'd0, 12'h007), 1'b0, 12'd0, 32'h0);
        tbl[6]  = mk(e_u(LUI, 5'd6, 20'h80FF8),           1'b0, 12'd6, 32'h80FF8000);
        tbl[7]  = mk(e_i(OPI, 3'd0, 5'd6, 5'd6, 12'hF01), 1'b0, 12'd6, 32'h80FF7F01);
        tbl[8]  = mk(e_s(3'd2, 5'd6, 5'd0, 12'h100),      1'b1, 12'h040, 32'h80FF7F01);
        tbl[9]  = mk(e_i(LD, 3'd0, 5'd7, 5'd0, 12'h103),  1'b0, 12'd7, 32'hFFFFFF80);
        tbl[10] = mk(e_i(LD, 3'd4, 5'd8, 5'd0, 12'h101),  1'b0, 12'd8, 32'h0000007F);
        tbl[11] = mk(e_i(LD, 3'd1, 5'd9, 5'd0, 12'h102),  1'b0, 12'd9, 32'hFFFF80FF);
        tbl[12] = mk(e_i(OPI, 3'd0, 5'd10, 5'd0, 12'h0AA), 1'b0, 12'd10, 32'h000000AA);
        tbl[13] = mk(e_s(3'd0, 5'd10, 5'd0, 12'h101),     1'b1, 12'h040, 32'h80FFAA01);
        tbl[14] = mk(e_i(LD, 3'd2, 5'd11, 5'd0, 12'h100), 1'b0, 12'd11, 32'h80FFAA01);
        tbl[15] = mk(e_i(LD, 3'd5, 5'd12, 5'd0, 12'h103), 1'b0, 12'd12, 32'h000080FF);
        tbl[16] = mk(e_s(3'd1, 5'd10, 5'd0, 12'h102),     1'b1, 12'h040, 32'h00AAAA01);
        tbl[17] = mk(e_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd13), 1'b0, 12'd13, 32'h1);
        tbl[18] = mk(e_u(AUIPC, 5'd14, 20'h00001),        1'b0, 12'd14, 32'h00001048);
        tbl[19] = mk(e_r(7'h00, 5'd5, 5'd10, 3'd1, 5'd15), 1'b0, 12'd15, 32'h0000AA00);
        tbl[20] = mk(e_r(7'h20, 5'd4, 5'd1, 3'd5, 5'd16), 1'b0, 12'd16, 32'hFFFFFFFC);
        tbl[21] = mk(32'h00100073,                        1'b0, 12'd1, 32'hFFFFFFF8);
        tbl[22] = mk(e_r(7'h00, 5'd2, 5'd6, 3'd7, 5'd17), 1'b0, 12'd17, 32'h80FF7F00);
        tbl[23] = mk(32'h00000073,                        1'b0, 12'd17, 32'h80FF7F00);

        clear_mem();
        for (int i = 0; i < 24; i++) poke(i, tbl[i].ins);
        do_reset();
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("vec%0d_fetch", i), dut.instrBusData, tbl[i].ins);
            step(1);
            chk($sformatf("vec%0d_pc", i), dut.cpu.PC, 32'(4 * (i + 1)));
            if (tbl[i].is_mem)
                chk($sformatf("vec%0d_mem", i), dut.ramMain.RAM[tbl[i].idx], tbl[i].exp);
            else
                chk($sformatf("vec%0d_reg", i), dut.cpu.regfile.rf[tbl[i].idx[4:0]], tbl[i].exp);
        end

        // Control flow
        clear_mem();
        for (int i = 0; i < 4; i++) poke(i, 32'h00000013);
        poke(4, e_b(3'd0, 5'd0, 5'd0, 13'h0008));
        poke(5, e_i(OPI, 3'd0, 5'd20, 5'd0, 12'h001));
        poke(6, e_j(5'd1, 21'h0000C));
        poke(7, e_b(3'd5, 5'd0, 5'd1, 13'h0008));
        poke(8, e_b(3'd6, 5'd0, 5'd1, 13'h1FE0));
        poke(9, e_i(JALR, 3'd0, 5'd0, 5'd1, 12'h001));
        do_reset();
        step(4);
        chk("cf_reach_beq", dut.cpu.PC, 32'h10);
        step(1);
        chk("cf_beq_taken", dut.cpu.PC, 32'h18);
        step(1);
        chk("cf_jal_pc", dut.cpu.PC, 32'h24);
        chk("cf_jal_link", dut.cpu.regfile.rf[1], 32'h1C);
        step(1);
        chk("cf_jalr_pc", dut.cpu.PC, 32'h1C);
        step(1);
        chk("cf_bge_not_taken", dut.cpu.PC, 32'h20);
        step(1);
        chk("cf_bltu_back", dut.cpu.PC, 32'h0);
        chk("cf_skipped_x20", dut.cpu.regfile.rf[20], 32'h0);

        // Reset asserted while a store is in flight
        clear_mem();
        sw_ins = e_s(3'd2, 5'd1, 5'd0, 12'h200);
        poke(0, e_u(LUI, 5'd5, 20'h12345));
        poke(1, e_i(OPI, 3'd0, 5'd1, 5'd1, 12'h001));
        poke(2, sw_ins);
        poke(3, e_j(5'd0, 21'h1FFFF8));
        do_reset();
        step(6);
        for (int k = 0; k < 20 && dut.instrBusData !== sw_ins; k++) step(1);
        chk("mid_sync", dut.instrBusData, sw_ins);
        chk("mid_x5_live", dut.cpu.regfile.rf[5], 32'h12345000);
        old_word = dut.ramMain.RAM[12'h080];
        sysRes = 1'b1;
        step(1);
        sysRes = 1'b0;
        chk("mid_pc", dut.cpu.PC, 32'h0);
        for (int r = 0; r < 32; r++) chk($sformatf("mid_x%0d", r), dut.cpu.regfile.rf[r], 32'h0);
        chk("mid_ram_kept", dut.ramMain.RAM[12'h080], old_word);

        // Random programs against the instruction-level model
        for (int p = 0; p < 2; p++) begin
            clear_mem();
            for (int i = 0; i < 200; i++) poke(i, rand_ins());
            for (int i = 12'h180; i < 12'h200; i++) poke(i, $urandom);
            for (int r = 0; r < 32; r++) m_x[r] = 32'h0;
            m_pc = 32'h0;
            do_reset();
            for (int s = 0; s < 200; s++) begin
                model_step();
                step(1);
                chk($sformatf("rand%0d_s%0d_pc", p, s), dut.cpu.PC, m_pc);
                for (int r = 0; r < 32; r++)
                    chk($sformatf("rand%0d_s%0d_x%0d", p, s, r), dut.cpu.regfile.rf[r], m_x[r]);
            end
            for (int i = 12'h180; i < 12'h200; i++)
                chk($sformatf("rand%0d_mem%0h", p, i), dut.ramMain.RAM[i], m_mem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vesp_top.md
# vesp_top

Top-level single-cycle RV32I system: one CPU core (`cpu`) and one unified instruction/data RAM (`ramMain`) on a single clock. Every instruction is fetched, executed and retired in one `sysClk` cycle. The block has no functional I/O beyond clock and reset. Benches preload the program into RAM and observe the instruction bus, PC, register file and RAM through fixed hierarchical names.

## Interface
- `MEM_WORDS`, default 4096: RAM depth in 32-bit words (16 KiB); power of two.
- `sysClk`  in  1  system clock; all state updates on its rising edge.
- `sysRes`  in  1  reset, synchronous and active-high.
- Required internal names, used by benches:
  - `ramMain.RAM`: `reg [31:0]` array `[0:MEM_WORDS-1]`, loadable by `$readmemh`.
  - `instrBusData`: 32-bit instruction currently fetched.
  - `cpu.PC`: program counter.
  - `cpu.regfile.rf[0:31]`: register file.
  - `cpu.instruction`: copy of `instrBusData`.

## Operation
- Fetch:
  - `instrBusData = RAM[PC[log2(MEM_WORDS)+1:2]]`, combinational read.
  - Address bits above the RAM range are ignored, so accesses wrap modulo 4·`MEM_WORDS` bytes.
  - `PC[1:0]` are always 0.
- Decode and execute the full RV32I base set:
  - LUI, AUIPC, JAL, JALR (target bit 0 cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, SB/SH/SW.
  - All OP-IMM and OP (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
- Immediates: I/S/B/U/J formats, sign-extended to 32 bits. Shift amount = low 5 bits of rs2 or of imm.
- Next PC:
  - PC+4 by default.
  - PC+immB on a taken branch.
  - PC+immJ for JAL.
  - (rs1+immI)&~1 for JALR.
  - JAL/JALR write PC+4 to rd.
- Register file:
  - 32×32 bits; two combinational read ports, one write port written on the rising edge.
  - x0 reads 0 and writes to it are discarded.
  - rd may equal rs1/rs2: reads see the old value, the write lands at the edge.
- Loads: data read from RAM combinationally; the byte or half is selected by `addr[1:0]` / `addr[1]`.
  - LB/LH sign-extend the selected byte or half.
  - LBU/LHU zero-extend it.
  - LW ignores `addr[1:0]`.
  - Misaligned halves ignore bit 0.
- Stores: written on the rising edge with byte enables.
  - SB writes only the lane addressed by `addr[1:0]`.
  - SH writes the half selected by `addr[1]`.
  - SW writes the full word.
  - A store to the instruction's own word is seen by the next fetch.
- The following retire as NOPs (PC+4, no state change); no traps are implemented:
  - ECALL (0x00000073) and EBREAK (0x00100073).
  - FENCE.
  - SYSTEM/CSR instructions.
  - Unknown opcodes.
- RAM contents are never cleared by reset.

## Timing
- Single-cycle: one instruction retires per rising edge while `sysRes`=0.
- Reset, sampled at the rising edge with `sysRes`=1:
  - PC ← 0.
  - All registers ← 0.
  - No register-file or RAM write occurs that cycle.
- First instruction: the word at address 0 is on `instrBusData` from the first edge where `sysRes` was 1. It retires at the first edge with `sysRes`=0.
- Reset asserted mid-program: takes effect at the next edge. The in-flight instruction is discarded and its writes are suppressed.
- Combinational path per cycle: fetch → decode → regfile read → ALU/RAM read → writeback mux. No stalls, no handshakes.

## Test plan
- Reset/fetch:
  - Stimulus: RAM[0]=0x00500093 (addi x1,x0,5), RAM[1]=0x00000073; pulse `sysRes` for one edge.
  - Required: after 1 edge PC=4 and x1=5; `instrBusData`=0x00000073 next.
- ALU:
  - Stimulus: x1=-8 via addi.
  - Required: `srai x2,x1,1` → x2=0xFFFFFFFC; `srli x3,x1,1` → x3=0x7FFFFFFC; `sltu x4,x0,x1` → x4=1; `sub x5,x0,x1` → x5=8.
- Loads/stores:
  - Stimulus: `sw` 0x80FF7F01 to byte address 0x100.
  - Required: `lb` @0x103 → 0xFFFFFF80; `lbu` @0x101 → 0x7F; `lh` @0x102 → 0xFFFF80FF; `sb` 0xAA @0x101 then `lw` @0x100 → 0x80FFAA01.
- Control flow:
  - Stimulus: `beq x0,x0,+8` at 0x10; `jal x1,+12` at 0x18; `jalr x0,x1,1` at 0x24.
  - Required: PC goes 0x10→0x18; 0x18→0x24 with x1=0x1C; 0x24→0x1C.
- x0 and terminators:
  - Required: `addi x0,x0,7` leaves x0=0.
  - Required: program reaching 0x00100073 shows it on `instrBusData` with no state change; PC advances by 4 after it.
- Reset mid-run:
  - Stimulus: assert `sysRes` during a loop of `sw` to 0x200.
  - Required: at that edge, PC=0, all x-regs=0, RAM[0x80] unchanged.
